// File: rtl/alu_pkg.sv
// Shared opcode/state definitions for the ALU operation sequencer.
package alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OPC_ADD = 3'b000;
  localparam logic [OP_W-1:0] OPC_SUB = 3'b001;
  localparam logic [OP_W-1:0] OPC_AND = 3'b010;
  localparam logic [OP_W-1:0] OPC_OR  = 3'b011;
  localparam logic [OP_W-1:0] OPC_XOR = 3'b100;
  localparam logic [OP_W-1:0] OPC_SHL = 3'b101;
  localparam logic [OP_W-1:0] OPC_SHR = 3'b110;
  localparam logic [OP_W-1:0] OPC_MUL = 3'b111;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = OPC_ADD,
    OP_SUB = OPC_SUB,
    OP_AND = OPC_AND,
    OP_OR  = OPC_OR,
    OP_XOR = OPC_XOR,
    OP_SHL = OPC_SHL,
    OP_SHR = OPC_SHR,
    OP_MUL = OPC_MUL
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

  function automatic logic op_is_shift(input alu_op_e op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Result flag derivation; raw carry/overflow are masked per opcode.
// ALU_OP_SEQUENCER_MUL_EN selects whether MUL is a legal opcode.
module alu_flag_gen import alu_pkg::*; #(
  parameter int Nbits = 4
) (
  input  logic [Nbits-1:0] result,
  input  logic             carry,
  input  logic             overflow,
  input  alu_op_e          op,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_illegal
);

  // Per-opcode flag selection
  always_comb begin
    flag_zero    = (result == {Nbits{1'b0}});
    flag_neg     = result[Nbits-1];
    flag_carry   = 1'b0;
    flag_ovf     = 1'b0;
    flag_illegal = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        flag_carry = carry;
        flag_ovf   = overflow;
      end
      OP_SHL, OP_SHR: begin
        flag_carry = carry;
      end
      OP_MUL: begin
`ifdef ALU_OP_SEQUENCER_MUL_EN
        flag_carry = carry;
`else
        flag_illegal = 1'b1;
`endif
      end
      default: begin
        flag_carry = 1'b0;
        flag_ovf   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU sequencer: IDLE accepts, EXEC iterates shifts/multiply, DONE holds result.
// Define ALU_OP_SEQUENCER_MUL_EN to build the shift-add multiplier; otherwise MUL is flagged illegal.
module alu_op_sequencer import alu_pkg::*; #(
  parameter int Nbits = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [2:0]       REQ_OP,
  input  logic [Nbits-1:0] REQ_A,
  input  logic [Nbits-1:0] REQ_B,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [Nbits-1:0] RES_Y,
  output logic             FLAG_ZERO,
  output logic             FLAG_NEG,
  output logic             FLAG_CARRY,
  output logic             FLAG_OVF,
  output logic             FLAG_ILLEGAL,
  output logic             BUSY
);

  localparam int               CW      = $clog2(Nbits + 1);
  localparam logic [Nbits-1:0] NB_W    = Nbits'(Nbits);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);

  alu_state_e       state_r;
  alu_op_e          op_r;
  logic [Nbits-1:0] work_r;
  logic [Nbits-1:0] res_y_r;
  logic [CW-1:0]    cnt_r;
  logic             cout_r;
  logic             res_valid_r;
  logic             ready_r;
  logic             busy_r;
  logic             zero_r, neg_r, carry_r, ovf_r, illegal_r;

`ifdef ALU_OP_SEQUENCER_MUL_EN
  logic [Nbits-1:0] a_r;
  logic [Nbits-1:0] hi_r;
  logic [Nbits-1:0] step_hi_s;
  logic [Nbits:0]   step_sum_s;
`endif

  alu_op_e          req_op_s;
  alu_op_e          fin_op_s;
  logic [Nbits:0]   sum_s;
  logic [Nbits:0]   dif_s;
  logic [CW-1:0]    k_s;
  logic [CW-1:0]    load_cnt_s;
  logic [Nbits-1:0] load_work_s;
  logic [Nbits-1:0] idle_y_s;
  logic             idle_c_s;
  logic             idle_v_s;
  logic             multi_s;
  logic [Nbits-1:0] step_work_s;
  logic             step_c_s;
  logic [Nbits-1:0] fin_y_s;
  logic             fin_c_s;
  logic             fin_v_s;
  logic             f_zero_s, f_neg_s, f_carry_s, f_ovf_s, f_illegal_s;

  // Decode an incoming request: single-cycle results and multi-cycle setup
  always_comb begin
    req_op_s    = alu_op_e'(REQ_OP);
    k_s         = CW'(REQ_B % NB_W);
    sum_s       = {1'b0, REQ_A} + {1'b0, REQ_B};
    dif_s       = {1'b0, REQ_A} + {1'b0, ~REQ_B} + {{Nbits{1'b0}}, 1'b1};
    idle_y_s    = {Nbits{1'b0}};
    idle_c_s    = 1'b0;
    idle_v_s    = 1'b0;
    multi_s     = 1'b0;
    load_cnt_s  = {CW{1'b0}};
    load_work_s = REQ_A;
    case (req_op_s)
      OP_ADD: begin
        idle_y_s = sum_s[Nbits-1:0];
        idle_c_s = sum_s[Nbits];
        idle_v_s = (REQ_A[Nbits-1] == REQ_B[Nbits-1]) && (sum_s[Nbits-1] != REQ_A[Nbits-1]);
      end
      OP_SUB: begin
        // No carry-out of A + ~B + 1 means a borrow occurred
        idle_y_s = dif_s[Nbits-1:0];
        idle_c_s = ~dif_s[Nbits];
        idle_v_s = (REQ_A[Nbits-1] != REQ_B[Nbits-1]) && (dif_s[Nbits-1] != REQ_A[Nbits-1]);
      end
      OP_AND:  idle_y_s = REQ_A & REQ_B;
      OP_OR:   idle_y_s = REQ_A | REQ_B;
      OP_XOR:  idle_y_s = REQ_A ^ REQ_B;
      OP_SHL, OP_SHR: begin
        idle_y_s   = REQ_A;
        multi_s    = (k_s != {CW{1'b0}});
        load_cnt_s = k_s;
      end
      OP_MUL: begin
`ifdef ALU_OP_SEQUENCER_MUL_EN
        multi_s     = 1'b1;
        load_cnt_s  = CW'(Nbits);
        load_work_s = REQ_B;
`else
        idle_y_s = {Nbits{1'b0}};
`endif
      end
      default: idle_y_s = {Nbits{1'b0}};
    endcase
  end

  // One iteration step of the operation held in EXEC
  always_comb begin
    step_work_s = work_r;
    step_c_s    = cout_r;
`ifdef ALU_OP_SEQUENCER_MUL_EN
    step_sum_s = {1'b0, hi_r} + (work_r[0] ? {1'b0, a_r} : {(Nbits+1){1'b0}});
    step_hi_s  = hi_r;
`endif
    case (op_r)
      OP_SHL: begin
        step_work_s = {work_r[Nbits-2:0], 1'b0};
        step_c_s    = work_r[Nbits-1];
      end
      OP_SHR: begin
        step_work_s = {1'b0, work_r[Nbits-1:1]};
        step_c_s    = work_r[0];
      end
`ifdef ALU_OP_SEQUENCER_MUL_EN
      OP_MUL: begin
        // {hi, multiplier} shifts right; the low half collects product bits
        step_hi_s   = step_sum_s[Nbits:1];
        step_work_s = {step_sum_s[0], work_r[Nbits-1:1]};
        step_c_s    = |step_sum_s[Nbits:1];
      end
`endif
      default: begin
        step_work_s = work_r;
        step_c_s    = cout_r;
      end
    endcase
  end

  // Select what gets latched on entry to DONE
  always_comb begin
    if (state_r == ST_EXEC) begin
      fin_y_s  = step_work_s;
      fin_c_s  = step_c_s;
      fin_v_s  = 1'b0;
      fin_op_s = op_r;
    end else begin
      fin_y_s  = idle_y_s;
      fin_c_s  = idle_c_s;
      fin_v_s  = idle_v_s;
      fin_op_s = req_op_s;
    end
  end

  alu_flag_gen #(.Nbits(Nbits)) u_flag_gen (
    .result       (fin_y_s),
    .carry        (fin_c_s),
    .overflow     (fin_v_s),
    .op           (fin_op_s),
    .flag_zero    (f_zero_s),
    .flag_neg     (f_neg_s),
    .flag_carry   (f_carry_s),
    .flag_ovf     (f_ovf_s),
    .flag_illegal (f_illegal_s)
  );

  // Sequencer FSM with registered handshake, result and flags
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= ST_IDLE;
      op_r        <= OP_ADD;
      work_r      <= {Nbits{1'b0}};
      res_y_r     <= {Nbits{1'b0}};
      cnt_r       <= {CW{1'b0}};
      cout_r      <= 1'b0;
      res_valid_r <= 1'b0;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
      zero_r      <= 1'b0;
      neg_r       <= 1'b0;
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
      illegal_r   <= 1'b0;
`ifdef ALU_OP_SEQUENCER_MUL_EN
      a_r         <= {Nbits{1'b0}};
      hi_r        <= {Nbits{1'b0}};
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (REQ_VALID) begin
            op_r    <= req_op_s;
            work_r  <= load_work_s;
            cout_r  <= 1'b0;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
`ifdef ALU_OP_SEQUENCER_MUL_EN
            a_r     <= REQ_A;
            hi_r    <= {Nbits{1'b0}};
`endif
            if (multi_s) begin
              state_r <= ST_EXEC;
              cnt_r   <= load_cnt_s;
            end else begin
              state_r     <= ST_DONE;
              res_valid_r <= 1'b1;
              res_y_r     <= fin_y_s;
              zero_r      <= f_zero_s;
              neg_r       <= f_neg_s;
              carry_r     <= f_carry_s;
              ovf_r       <= f_ovf_s;
              illegal_r   <= f_illegal_s;
            end
          end
        end
        ST_EXEC: begin
          cnt_r  <= cnt_r - CNT_ONE;
          work_r <= step_work_s;
          cout_r <= step_c_s;
`ifdef ALU_OP_SEQUENCER_MUL_EN
          hi_r   <= step_hi_s;
`endif
          if (cnt_r == CNT_ONE) begin
            state_r     <= ST_DONE;
            res_valid_r <= 1'b1;
            res_y_r     <= fin_y_s;
            zero_r      <= f_zero_s;
            neg_r       <= f_neg_s;
            carry_r     <= f_carry_s;
            ovf_r       <= f_ovf_s;
            illegal_r   <= f_illegal_s;
          end
        end
        ST_DONE: begin
          if (RES_READY) begin
            state_r     <= ST_IDLE;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            ready_r     <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= {CW{1'b0}};
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          ready_r     <= 1'b1;
        end
      endcase
    end
  end

  assign REQ_READY    = ready_r;
  assign RES_VALID    = res_valid_r;
  assign RES_Y        = res_y_r;
  assign BUSY         = busy_r;
  assign FLAG_ZERO    = zero_r;
  assign FLAG_NEG     = neg_r;
  assign FLAG_CARRY   = carry_r;
  assign FLAG_OVF     = ovf_r;
  assign FLAG_ILLEGAL = illegal_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer (Nbits=4): directed vectors plus a cycle-level reference model.
module tb_alu_op_sequencer;

  localparam int NB = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          REQ_VALID = 1'b0;
  logic          REQ_READY;
  logic [2:0]    REQ_OP = 3'b000;
  logic [NB-1:0] REQ_A = 4'b0000;
  logic [NB-1:0] REQ_B = 4'b0000;
  logic          RES_VALID;
  logic          RES_READY = 1'b0;
  logic [NB-1:0] RES_Y;
  logic          FLAG_ZERO, FLAG_NEG, FLAG_CARRY, FLAG_OVF, FLAG_ILLEGAL;
  logic          BUSY;
  logic [4:0]    flags;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_ops = 0;
  int   dut_deliv = 0;
  bit   cmp_en = 1'b0;

  // reference timeline: 0 idle, 1 computing, 2 result pending
  int         ph = 0;
  int         remain = 0;
  int         m_y = 0;
  logic [4:0] m_f = 5'b00000;

  alu_op_sequencer #(.Nbits(NB)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_OP(REQ_OP), .REQ_A(REQ_A), .REQ_B(REQ_B), .RES_VALID(RES_VALID),
    .RES_READY(RES_READY), .RES_Y(RES_Y), .FLAG_ZERO(FLAG_ZERO), .FLAG_NEG(FLAG_NEG),
    .FLAG_CARRY(FLAG_CARRY), .FLAG_OVF(FLAG_OVF), .FLAG_ILLEGAL(FLAG_ILLEGAL), .BUSY(BUSY)
  );

  assign flags = {FLAG_ZERO, FLAG_NEG, FLAG_CARRY, FLAG_OVF, FLAG_ILLEGAL};

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= (1 << (NB - 1))) ? v - (1 << NB) : v;
  endfunction

  // Arithmetic definition of each opcode on plain integers
  function automatic void model(input logic [2:0] op, input int a, input int b,
                                output int y, output logic [4:0] f, output int lat);
    int m, k, r, c, v, il, s;
    m = 1 << NB; k = b % NB; r = 0; c = 0; v = 0; il = 0; lat = 1;
    case (op)
      3'b000: begin r = a + b; c = (r >= m) ? 1 : 0; s = sx(a) + sx(b);
                    v = (s > m/2 - 1 || s < -m/2) ? 1 : 0; end
      3'b001: begin r = a - b + m; c = (a < b) ? 1 : 0; s = sx(a) - sx(b);
                    v = (s > m/2 - 1 || s < -m/2) ? 1 : 0; end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      3'b101: begin r = a << k; c = (k == 0) ? 0 : ((a >> (NB - k)) & 1); lat = k + 1; end
      3'b110: begin r = a >> k; c = (k == 0) ? 0 : ((a >> (k - 1)) & 1); lat = k + 1; end
      default: begin
`ifdef ALU_OP_SEQUENCER_MUL_EN
        r = a * b; c = ((r >> NB) != 0) ? 1 : 0; lat = NB + 1;
`else
        r = 0; il = 1;
`endif
      end
    endcase
    y = r % m;
    f = {y == 0, ((y >> (NB - 1)) & 1) != 0, c != 0, v != 0, il != 0};
  endfunction

  // Reference timeline advances on each clock edge
  always @(posedge CLK or negedge RST_N) begin : ref_model
    int ty, tl;
    logic [4:0] tf;
    if (!RST_N) begin
      ph <= 0;
      remain <= 0;
    end else begin
      case (ph)
        0: if (REQ_VALID) begin
             model(REQ_OP, int'(REQ_A), int'(REQ_B), ty, tf, tl);
             m_y <= ty;
             m_f <= tf;
             remain <= tl - 1;
             ph <= (tl == 1) ? 2 : 1;
           end
        1: begin
             remain <= remain - 1;
             if (remain == 1) ph <= 2;
           end
        2: if (RES_READY) ph <= 0;
        default: ph <= 0;
      endcase
    end
  end

  always @(posedge CLK) begin
    if (RST_N && RES_VALID && RES_READY) dut_deliv <= dut_deliv + 1;
  end

  // Every-cycle comparison against the reference
  always @(negedge CLK) begin
    if (cmp_en) begin
      if (!RST_N) begin
        chk("cmp_rst_y", 32'(RES_Y), 32'd0);
        chk("cmp_rst_flags", 32'(flags), 32'd0);
      end
      chk("cmp_valid", 32'(RES_VALID), (ph == 2) ? 32'd1 : 32'd0);
      chk("cmp_ready", 32'(REQ_READY), (ph == 0) ? 32'd1 : 32'd0);
      chk("cmp_busy", 32'(BUSY), (ph != 0) ? 32'd1 : 32'd0);
      if (ph == 2) begin
        chk("cmp_y", 32'(RES_Y), 32'(m_y));
        chk("cmp_flags", 32'(flags), 32'(m_f));
      end
    end
  end

  task automatic do_op(input string nm, input logic [2:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] ey, input logic [4:0] ef,
                       input int elat, input int hold, input bit keep_valid);
    int n;
    @(posedge CLK); #1;
    REQ_VALID = 1'b1; REQ_OP = op; REQ_A = a; REQ_B = b;
    @(posedge CLK); #1;
    n_ops++;
    if (keep_valid) begin
      REQ_OP = 3'b000; REQ_A = ~a; REQ_B = ~b;
    end else begin
      REQ_VALID = 1'b0;
    end
    n = 1;
    while (!RES_VALID && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'(elat));
    chk({nm, "_y"}, 32'(RES_Y), 32'(ey));
    chk({nm, "_flags"}, 32'(flags), 32'(ef));
    repeat (hold) begin
      @(posedge CLK); #1;
      chk({nm, "_hold_y"}, 32'(RES_Y), 32'(ey));
      chk({nm, "_hold_flags"}, 32'(flags), 32'(ef));
      chk({nm, "_hold_ready"}, 32'(REQ_READY), 32'd0);
    end
    RES_READY = 1'b1; REQ_VALID = 1'b0;
    @(posedge CLK); #1;
    RES_READY = 1'b0;
    chk({nm, "_ack"}, 32'(RES_VALID), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int d0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", 32'(REQ_READY), 32'd1);
    chk("rst_valid", 32'(RES_VALID), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_y", 32'(RES_Y), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    cmp_en = 1'b1;
    @(negedge CLK);
    RST_N = 1'b1;

    do_op("add_wrap", 3'b000, 4'b0111, 4'b1001, 4'b0000, 5'b10100, 1, 0, 1'b0);
    do_op("sub_neg",  3'b001, 4'b0011, 4'b0101, 4'b1110, 5'b01100, 1, 0, 1'b0);
    do_op("add_ovf",  3'b000, 4'b0111, 4'b0001, 4'b1000, 5'b01010, 1, 0, 1'b0);
    do_op("sub_ovf",  3'b001, 4'b1000, 4'b0001, 4'b0111, 5'b00010, 1, 0, 1'b0);
    do_op("and",      3'b010, 4'b1100, 4'b1010, 4'b1000, 5'b01000, 1, 0, 1'b0);
    do_op("or",       3'b011, 4'b1100, 4'b0011, 4'b1111, 5'b01000, 1, 0, 1'b0);
    do_op("xor_zero", 3'b100, 4'b1010, 4'b1010, 4'b0000, 5'b10000, 1, 0, 1'b0);
    do_op("shl_k2",   3'b101, 4'b0101, 4'b0010, 4'b0100, 5'b00100, 3, 0, 1'b0);
    do_op("shr_k0",   3'b110, 4'b0101, 4'b0100, 4'b0101, 5'b00000, 1, 0, 1'b0);
    do_op("shr_k3",   3'b110, 4'b1000, 4'b0111, 4'b0001, 5'b00000, 4, 0, 1'b0);
    do_op("shl_mod",  3'b101, 4'b1001, 4'b1101, 4'b0010, 5'b00100, 2, 0, 1'b0);
`ifdef ALU_OP_SEQUENCER_MUL_EN
    do_op("mul_15",   3'b111, 4'b0101, 4'b0011, 4'b1111, 5'b01000, 5, 0, 1'b0);
    do_op("mul_18",   3'b111, 4'b0110, 4'b0011, 4'b0010, 5'b00100, 5, 0, 1'b0);
`else
    do_op("mul_15",   3'b111, 4'b0101, 4'b0011, 4'b0000, 5'b10001, 1, 0, 1'b0);
    do_op("mul_18",   3'b111, 4'b0110, 4'b0011, 4'b0000, 5'b10001, 1, 0, 1'b0);
`endif
    do_op("bp_shl",   3'b101, 4'b0101, 4'b0010, 4'b0100, 5'b00100, 3, 3, 1'b1);

    // Reset during the second cycle of a MUL discards it
    d0 = dut_deliv;
    @(posedge CLK); #1;
    REQ_VALID = 1'b1; REQ_OP = 3'b111; REQ_A = 4'b0101; REQ_B = 4'b0011;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    @(posedge CLK); #3;
    RST_N = 1'b0;
    #1;
    chk("mrst_valid", 32'(RES_VALID), 32'd0);
    chk("mrst_busy", 32'(BUSY), 32'd0);
    chk("mrst_ready", 32'(REQ_READY), 32'd1);
    chk("mrst_y", 32'(RES_Y), 32'd0);
    chk("mrst_flags", 32'(flags), 32'd0);
    @(posedge CLK); #2;
    RST_N = 1'b1;
    repeat (8) @(posedge CLK);
    #1;
    chk("mrst_no_result", 32'(dut_deliv), 32'(d0));
    do_op("add_after_rst", 3'b000, 4'b0010, 4'b0011, 4'b0101, 5'b00000, 1, 0, 1'b0);

    repeat (2) @(posedge CLK);
    #1;
    chk("deliveries", 32'(dut_deliv), 32'(n_ops));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter Nbits, default 4, meaning operand/result width (minimum 2).
REQ-002 SHALL have ports:
- CLK  input  1  sole clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- REQ_VALID  input  1  request present.
- REQ_READY  output  1  request accepted when high with REQ_VALID.
- REQ_OP  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
- REQ_A, REQ_B  input  Nbits  operands.
- RES_VALID  output  1  result present.
- RES_READY  input  1  consumer takes result.
- RES_Y  output  Nbits  result.
- FLAG_ZERO, FLAG_NEG, FLAG_CARRY, FLAG_OVF, FLAG_ILLEGAL  output  1 each  result flags.
- BUSY  output  1  high in any state other than IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, EXEC and DONE.
REQ-004 IDLE: REQ_READY=1; on REQ_VALID, capture REQ_OP/A/B; single-cycle op or zero shift count -> DONE; otherwise -> EXEC.
REQ-005 EXEC: one shift or add step per cycle; the iteration counter decrements each cycle; -> DONE when the count is exhausted.
REQ-006 DONE: RES_VALID=1; RES_Y and flags held stable until RES_READY; then -> IDLE.
REQ-007 REQ_READY SHALL be 0 in EXEC and DONE; REQ_VALID is ignored there, and requests never overlap.
REQ-008 Latency from acceptance edge to RES_VALID high:
- ADD/SUB/AND/OR/XOR: 1 cycle.
- SHL/SHR: k+1 cycles, where k = REQ_B mod Nbits (k=0 gives 1 cycle, RES_Y=A).
- MUL: Nbits+1 cycles.
REQ-009 Arithmetic is modulo 2^Nbits:
- SUB = A + ~B + 1.
- SHL/SHR are logical, zero-filled.
- MUL is unsigned shift-add; RES_Y is the low Nbits of the product.
REQ-010 FLAG_ZERO=1 iff RES_Y is all zeros; FLAG_NEG=RES_Y[Nbits-1].
REQ-011 FLAG_CARRY by opcode:
- ADD: carry-out.
- SUB: borrow (A<B unsigned).
- SHL/SHR: last bit shifted out, or 0 if k=0.
- MUL: 1 iff the high product half is nonzero.
- Logic ops: 0.
REQ-012 FLAG_OVF SHALL be signed two's-complement overflow for ADD/SUB, else 0.
REQ-013 Flags SHALL be registered on entry to DONE, never combinational from request inputs.

Reset
REQ-014 RST_N low SHALL asynchronously force state IDLE, counter 0 and RES_Y 0, with RES_VALID, BUSY and all flags at 0; REQ_READY=1 immediately after reset release.
REQ-015 Reset mid-EXEC or mid-DONE SHALL discard the operation with no result emitted.

Configuration
REQ-016 Macro ALU_OP_SEQUENCER_MUL_EN defined: MUL SHALL behave per REQ-008/009/011.
REQ-017 Macro undefined: the multiply datapath SHALL be absent; a MUL request SHALL go IDLE->DONE in 1 cycle with RES_Y=0, FLAG_ZERO=1, FLAG_ILLEGAL=1 and other flags 0.
REQ-018 FLAG_ILLEGAL SHALL be 0 in all other cases.

Structure
REQ-019 A shared package alu_pkg SHALL hold the opcode enum, the FSM state enum and opcode constants.
REQ-020 Flag derivation SHALL be a sub-module alu_flag_gen (inputs result, carry, overflow and op; outputs the five flags).

Verification (Nbits=4)
REQ-021 ADD A=0111 B=1001 -> after 1 cycle RES_Y=0000, ZERO=1, CARRY=1, OVF=0, NEG=0.
REQ-022 SUB A=0011 B=0101 -> RES_Y=1110, NEG=1, CARRY=1, OVF=0; ADD 0111+0001 -> RES_Y=1000, OVF=1.
REQ-023 SHL A=0101 B=0010 -> RES_VALID after 3 cycles, RES_Y=0100, CARRY=1; SHR A=0101 B=0100 (k=0) -> 1 cycle, RES_Y=0101, CARRY=0.
REQ-024 MUL 0101*0011 -> after 5 cycles RES_Y=1111, CARRY=0; MUL 0110*0011 -> RES_Y=0010, CARRY=1; without the macro -> 1 cycle, RES_Y=0000, ILLEGAL=1.
REQ-025 Backpressure: hold RES_READY=0 for 3 cycles in DONE -> RES_Y and flags stable; REQ_READY=0 with REQ_VALID=1 throughout; one result delivered.
REQ-026 Assert RST_N=0 during cycle 2 of a MUL -> outputs clear asynchronously; no RES_VALID afterwards; the next ADD completes normally.
